ahb_lite_slave: RTL
===================

AHB_LITE_SLAVE -- requirements
Module: ahb_lite_slave

Interface
REQ-001 The block SHALL expose these parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width (fixed at 32).
- MEM_DEPTH, 16, number of 32-bit words.
- WAIT_STATES, 1, data-phase wait cycles for OKAY transfers (0..7).

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset. Ports:
- HCLK  in  1  bus clock, rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  combined bus ready, fed back from the ready-OR.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  this slave's ready, into the ready-OR.
- HRESP  out  1  0=OKAY, 1=ERROR.

Function
REQ-003 The block SHALL accept an address phase only on a cycle with HSEL=1, HREADY=1 and HTRANS[1]=1. On acceptance it SHALL register HADDR, HWRITE and HSIZE.
REQ-004 IDLE/BUSY transfers, or cycles with HSEL=0 and HREADY=1, SHALL produce a zero-wait OKAY response: HREADYOUT=1, HRESP=0.
REQ-005 An accepted transfer SHALL be flagged as an error if any of the following holds:
- HSIZE>2.
- The address is misaligned for HSIZE (half: HADDR[0]=1; word: HADDR[1:0]≠0).
- The word index HADDR[ADDR_WIDTH-1:2] ≥ MEM_DEPTH.
REQ-006 FSM states SHALL be IDLE, WAIT, ERR1, ERR2. Transitions:
- IDLE→WAIT on an accepted OKAY transfer when WAIT_STATES>0. With WAIT_STATES=0 it stays in IDLE and completes in one cycle.
- WAIT→IDLE after WAIT_STATES cycles with HREADYOUT=0; HREADYOUT=1 on the following (completion) cycle.
- IDLE→ERR1 on an accepted error transfer.
- ERR1→ERR2 unconditionally.
- ERR2→IDLE, or directly into a new accepted transfer.
REQ-007 Error response SHALL be two cycles:
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
- No memory write and no HRDATA update for an errored transfer.
REQ-008 Writes SHALL commit on the completion cycle (HREADYOUT=1), using HWDATA and byte enables decoded from registered HSIZE and HADDR[1:0] per AHB little-endian lane rules.
REQ-009 Reads SHALL present the full addressed word on HRDATA during the completion cycle. HRDATA SHALL hold its last value otherwise.
REQ-010 A read immediately following a write to the same word SHALL return the newly written bytes, including with WAIT_STATES=0. Bypass is used if needed.
REQ-011 An address phase coinciding with the completion cycle of the previous transfer SHALL be accepted, giving back-to-back pipelining with no dead cycle.
REQ-012 An address phase presented while HREADY=0 SHALL be ignored.

Reset
REQ-013 While HRESETn=0, outputs SHALL be HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, and all memory words 0.
REQ-014 Assertion of HRESETn mid-transfer, including mid-wait and mid-error, SHALL abort the transfer with no memory write. Normal operation SHALL resume on the first HCLK edge after deassertion.

Structure
REQ-015 Package ahb_pkg SHALL hold the HTRANS, HSIZE and HRESP encodings and the FSM state enum.
REQ-016 Storage SHALL be a sub-module ahb_slave_mem: MEM_DEPTH×32 register file, 4-bit byte-enable write port, asynchronous read port, async active-low reset clear.

Verification
REQ-017 Reset, then idle bus → HREADYOUT=1, HRESP=0, HRDATA=0x00000000.
REQ-018 WAIT_STATES=1: write word 0xDEADBEEF to 0x04, then read 0x04 → each data phase shows one HREADYOUT=0 cycle; the read returns 0xDEADBEEF.
REQ-019 Byte write 0xAA to 0x05 over word 0x11223344, then word read 0x04 → 0x1122AA44.
REQ-020 Read of 0x40 (MEM_DEPTH=16) → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged.
REQ-021 WAIT_STATES=0: back-to-back NONSEQ write 0x0 = 0x12345678 then read 0x0 → the read completes the next cycle returning 0x12345678.
REQ-022 HRESETn pulsed low during the WAIT of a write to 0x08 → HREADYOUT=1 immediately; a subsequent read of 0x08 returns 0x00000000.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and the byte-lane decoder
// used by the AHB-Lite slave and its storage.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_state_t;

    // Little-endian lane enables; only called with sizes already checked legal.
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lane;
            HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word-organised register file with per-byte write enables, a combinational
// read port and an asynchronous clear.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int IDX_W      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_slave.sv
// AHB-Lite memory slave with configurable data-phase wait states and a
// two-cycle ERROR response for illegal size, misalignment or out-of-range.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | address-phase slot; completion cycle when a transfer is pending
// WAIT    | data-phase wait cycles, HREADYOUT low
// ERR1    | first error cycle, HREADYOUT low, HRESP high
// ERR2    | second error cycle, HREADYOUT high, HRESP high
module ahb_lite_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0] WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    ahb_state_t state_q, state_d;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic       pend_q, pend_d;

    logic                  write_q;
    logic [3:0]            be_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] hrdata_q;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  trans_active;
    logic                  size_err, align_err, range_err, xfer_err;
    logic                  ready_out, accept, complete, mem_we;
    logic [ADDR_WIDTH-3:0] word_idx;

    always_comb begin
        trans_active = 1'b0;
        case (HTRANS)
            HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
        endcase
    end

    assign word_idx  = HADDR[ADDR_WIDTH-1:2];
    assign size_err  = HSIZE > HSIZE_WORD;
    assign align_err = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                       ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign range_err = word_idx >= (ADDR_WIDTH-2)'(MEM_DEPTH);
    assign xfer_err  = size_err || align_err || range_err;

    assign ready_out = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    // Gating on our own ready keeps the FSM safe even if HREADY is mis-wired.
    assign accept    = HSEL && HREADY && trans_active && ready_out;
    assign complete  = (state_q == ST_IDLE) && pend_q;
    assign mem_we    = complete && write_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 3'd0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pend_d     = pend_q;
        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
                if (accept) begin
                    if (xfer_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        pend_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d    = ST_WAIT;
                            wait_cnt_d = WS_M1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            write_q  <= 1'b0;
            be_q     <= 4'b0000;
            idx_q    <= '0;
            hrdata_q <= '0;
        end else begin
            if (accept) begin
                write_q <= HWRITE;
                be_q    <= byte_enables(HSIZE, HADDR[1:0]);
                idx_q   <= HADDR[IDX_W+1:2];
            end
            if (complete && !write_q) begin
                hrdata_q <= mem_rdata;
            end
        end
    end

    // Writes land at the end of their completion cycle, before any following
    // read can reach its own completion, so the async read port needs no bypass.
    ahb_slave_mem #(
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .we    (mem_we),
        .be    (be_q),
        .addr  (idx_q),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

    assign HRDATA    = (complete && !write_q) ? mem_rdata : hrdata_q;
    assign HREADYOUT = ready_out;
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule
